// File: rtl/srsw_pkg.sv
// srsw_pkg: shared widths and response bundle
// for the SRSW memory read-side front end.
package srsw_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 80;
  localparam int ID_W_DEF   = 4;

  typedef struct packed {
    logic [ID_W_DEF-1:0]   id;
    logic [DATA_W_DEF-1:0] data;
  } resp_t;

endpackage

// File: rtl/srsw_resp_fifo.sv
// srsw_resp_fifo: DEPTH-entry response buffer
// with wrapping pointers and an occupancy count.
module srsw_resp_fifo
  import srsw_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = resp_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head = mem_q[rd_ptr];

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1))
                ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1))
                ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/srsw_rd_stream.sv
// srsw_rd_stream: credit-protected read stream in front of
// a registered-address memory. Optional SRSW_RD_STATS_EN stats.
module srsw_rd_stream
  import srsw_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ID_W-1:0]   req_id,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ID_W-1:0]   resp_id,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef SRSW_RD_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic            fire_req;
  logic            pop;
  logic            inflight_q;
  logic [ID_W-1:0] id_q;
  logic [CW-1:0]   count;
  logic [CW:0]     credit;
  entry_t          push_data;
  entry_t          head;

  assign mem_raddr  = req_addr;
  assign fire_req   = req_valid & req_ready;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid & resp_ready;

  // A slot is reserved for the read in flight, and a pop
  // this cycle frees one, so resp_ready feeds req_ready.
  assign credit    = {1'b0, count}
                   + (CW + 1)'(inflight_q)
                   - (CW + 1)'(pop);
  assign req_ready = (credit < (CW + 1)'(DEPTH));

  assign push_data.id   = id_q;
  assign push_data.data = mem_rdata;
  assign resp_data      = head.data;
  assign resp_id        = head.id;

  // Track the accepted read whose data returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      id_q       <= '0;
    end else begin
      inflight_q <= fire_req;
      if (fire_req) begin
        id_q <= req_id;
      end
    end
  end

  srsw_resp_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef SRSW_RD_STATS_EN
  // Saturating counters of accepts and stalled request cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads  <= '0;
      stat_stalls <= '0;
    end else begin
      if (fire_req && stat_reads != '1) begin
        stat_reads <= stat_reads + 32'd1;
      end
      if (req_valid && !req_ready && stat_stalls != '1) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_srsw_rd_stream.sv
// tb_srsw_rd_stream: directed bench with a memory model
// and an in-order response scoreboard.
module tb_srsw_rd_stream;

  localparam int AW = 3;
  localparam int DW = 80;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [IW-1:0] req_id;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [IW-1:0] resp_id;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
`ifdef SRSW_RD_STATS_EN
  logic [31:0]   stat_reads;
  logic [31:0]   stat_stalls;
`endif

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] mem [8];
  logic [AW-1:0] raddr_q;

  logic [IW+DW-1:0] sb [$];
  int n_assert = 0;
  int n_fail   = 0;
  int fires    = 0;

  always #5 clk = ~clk;

  srsw_rd_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_id     (req_id),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata)
`ifdef SRSW_RD_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_stalls (stat_stalls)
`endif
  );

  // Memory model: registered read address, write-first.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= mem_raddr;
  end
  assign mem_rdata = mem[raddr_q];

  task automatic chk(input string tag,
                     input logic [IW+DW-1:0] obs,
                     input logic [IW+DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Scoreboard: decisions for the next edge, sampled mid-cycle.
  always @(negedge clk) begin
    logic [IW+DW-1:0] exp;
    logic [DW-1:0]    d;
    if (!rst_n) begin
      sb.delete();
      fires = 0;
    end else begin
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", {resp_id, resp_data}, 'x);
        end else begin
          exp = sb.pop_front();
          chk("resp", {resp_id, resp_data}, exp);
        end
      end
      if (req_valid && req_ready) begin
        d = (we && waddr == req_addr) ? wdata : mem[req_addr];
        sb.push_back({req_id, d});
        fires++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  initial begin
    int next_id;
    int acc;
    int guard;
    logic rdy;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    req_id = '0; resp_ready = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    rst_n = 1'b1;
    step();
    chk("idle_req_ready", req_ready, 1);
    chk("idle_resp_valid", resp_valid, 0);

    for (int a = 0; a < 8; a++) begin
      mem_write(AW'(a), DW'(80'h1_0001_0001 * (a + 1)));
    end
    mem_write(3'd3, 80'hA5);

    // Single read: 2-cycle latency.
    req_valid = 1'b1; req_addr = 3'd3; req_id = 4'd7;
    chk("raddr_follow", mem_raddr, 3);
    step();
    req_valid = 1'b0;
    chk("single_e0_valid", resp_valid, 0);
    step();
    chk("single_e1_valid", resp_valid, 1);
    chk("single_data", resp_data, 80'hA5);
    chk("single_id", resp_id, 7);
    step();
    chk("single_drained", resp_valid, 0);

    // Streaming 8 back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = AW'(i); req_id = IW'(i);
      chk("stream_ready", req_ready, 1);
      if (i >= 2) chk("stream_valid", resp_valid, 1);
      step();
    end
    req_valid = 1'b0;
    chk("stream_valid_7", resp_valid, 1);
    step();
    chk("stream_valid_8", resp_valid, 1);
    step();
    chk("stream_end", resp_valid, 0);

    // Backpressure: two accepts then three stalls.
    resp_ready = 1'b0;
    next_id = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_addr = AW'(next_id); req_id = IW'(next_id);
      rdy = req_ready;
      step();
      if (rdy) begin next_id++; acc++; end
    end
    chk("bp_accepts", acc, 2);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_head_valid", resp_valid, 1);
    chk("bp_head_id", resp_id, 0);
`ifdef SRSW_RD_STATS_EN
    chk("stat_stalls", stat_stalls, 3);
    chk("stat_reads", stat_reads, fires);
`endif
    resp_ready = 1'b1;
    guard = 0;
    while (next_id < 6 && guard < 20) begin
      req_valid = 1'b1;
      req_addr = AW'(next_id); req_id = IW'(next_id);
      rdy = req_ready;
      step();
      if (rdy) next_id++;
      guard++;
    end
    chk("bp_all_sent", next_id, 6);
    req_valid = 1'b0;
    guard = 0;
    while (resp_valid && guard < 10) begin
      step();
      guard++;
    end
    chk("bp_drained", resp_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Same-edge write and read of address 5.
    we = 1'b1; waddr = 3'd5; wdata = 80'h1234;
    req_valid = 1'b1; req_addr = 3'd5; req_id = 4'd9;
    step();
    we = 1'b0; req_valid = 1'b0;
    step();
    chk("wr_rd_valid", resp_valid, 1);
    chk("wr_rd_data", resp_data, 80'h1234);
    chk("wr_rd_id", resp_id, 9);
    step();

    // Reset with two buffered responses.
    resp_ready = 1'b0;
    next_id = 10; acc = 0; guard = 0;
    while (acc < 2 && guard < 6) begin
      req_valid = 1'b1;
      req_addr = AW'(next_id); req_id = IW'(next_id);
      rdy = req_ready;
      step();
      if (rdy) begin next_id++; acc++; end
      guard++;
    end
    req_valid = 1'b0;
    step();
    chk("mid_buffered", resp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_no_stale", resp_valid, 0);
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
